// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register and its load-use hazard logic.
// Compile with ID_EX_PERF_EN defined to build the hazard_cnt performance counter.
package id_ex_stage_pkg;

  typedef logic [4:0] regName_t;

  localparam int CTRL_WIDTH_DEF = 16;
  localparam int CNT_W          = 3;

  // A bubble carries an all-zero control bundle so EXECUTE treats it as a no-op.
  localparam logic ID_EX_BUBBLE_BIT = 1'b0;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } idex_state_t;

  typedef struct packed {
    idex_state_t      state;
    logic [CNT_W-1:0] cnt;
    regName_t         pend_rd;
  } idex_fsm_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/id_ex_stage_load_use_hazard.sv
// Combinational load-use hazard detector: the instruction in decode reads a
// register that the load currently in EXECUTE has not yet produced.
module load_use_hazard
  import id_ex_stage_pkg::*;
(
  input  logic     id_valid,
  input  regName_t id_rs1,
  input  regName_t id_rs2,
  input  logic     id_use_rs1,
  input  logic     id_use_rs2,
  input  logic     ex_valid,
  input  logic     ex_is_load,
  input  logic     ex_rd_wen,
  input  regName_t ex_rd,
  output logic     hazard
);

  logic producer;
  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    // x0 is hard-wired, so a load targeting it never produces anything to wait for.
    producer = ex_valid && ex_is_load && ex_rd_wen && (ex_rd != '0);
    rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
    rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
    hazard   = id_valid && producer && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall FSM, downstream hold and branch flush.
// ID_EX_PERF_EN enables the hazard_cnt stall counter; otherwise hazard_cnt reads 0.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = CTRL_WIDTH_DEF,
  parameter int LOAD_STALL = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [DATA_WIDTH-1:0] id_pc,
  input  regName_t              id_rs1,
  input  regName_t              id_rs2,
  input  regName_t              id_rd,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [DATA_WIDTH-1:0] id_regA,
  input  logic [DATA_WIDTH-1:0] id_regB,
  input  logic [DATA_WIDTH-1:0] id_imm,
  input  logic [CTRL_WIDTH-1:0] id_ctrl,
  input  logic                  id_is_load,
  input  logic                  id_rd_wen,
  input  logic                  ex_ready,
  input  logic                  flush,
  output logic                  ex_valid,
  output logic                  ex_is_load,
  output logic                  ex_rd_wen,
  output logic [DATA_WIDTH-1:0] ex_pc,
  output logic [DATA_WIDTH-1:0] ex_regA,
  output logic [DATA_WIDTH-1:0] ex_regB,
  output logic [DATA_WIDTH-1:0] ex_imm,
  output regName_t              ex_rs1,
  output regName_t              ex_rs2,
  output regName_t              ex_rd,
  output logic [CTRL_WIDTH-1:0] ex_ctrl,
  output logic                  id_stall,
  output logic [15:0]           hazard_cnt,
  output idex_fsm_t             dbg_fsm
);

  // Handshake: EXECUTE takes the ID/EX contents on any edge with ex_ready = 1;
  // with ex_ready = 0 the register holds and decode is stalled. Decode advances
  // on an edge only when id_stall = 0. flush beats every other condition.

  typedef struct packed {
    logic                  valid;
    logic                  is_load;
    logic                  rd_wen;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] regA;
    logic [DATA_WIDTH-1:0] regB;
    logic [DATA_WIDTH-1:0] imm;
    regName_t              rs1;
    regName_t              rs2;
    regName_t              rd;
    logic [CTRL_WIDTH-1:0] ctrl;
  } ex_bundle_t;

  ex_bundle_t ex_q;
  ex_bundle_t ex_d;
  idex_fsm_t  fsm;

  logic hazard;
  logic hold;
  logic in_wait;
  logic run_hazard;

  load_use_hazard u_hazard (
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_valid   (ex_q.valid),
    .ex_is_load (ex_q.is_load),
    .ex_rd_wen  (ex_q.rd_wen),
    .ex_rd      (ex_q.rd),
    .hazard     (hazard)
  );

  always_comb begin
    in_wait    = (fsm.state == WAIT);
    hold       = !flush && !ex_ready;
    // Detection only runs in RUN; WAIT simply counts out the remaining stall.
    run_hazard = !in_wait && hazard;
    id_stall   = !rst && !flush && (!ex_ready || in_wait || run_hazard);

    ex_d      = '0;
    ex_d.ctrl = {CTRL_WIDTH{ID_EX_BUBBLE_BIT}};
    if (!flush && !in_wait && !run_hazard && id_valid) begin
      ex_d.valid   = 1'b1;
      ex_d.is_load = id_is_load;
      ex_d.rd_wen  = id_rd_wen;
      ex_d.pc      = id_pc;
      ex_d.regA    = id_regA;
      ex_d.regB    = id_regB;
      ex_d.imm     = id_imm;
      ex_d.rs1     = id_rs1;
      ex_d.rs2     = id_rs2;
      ex_d.rd      = id_rd;
      ex_d.ctrl    = id_ctrl;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q        <= '0;
      fsm.state   <= RUN;
      fsm.cnt     <= '0;
      fsm.pend_rd <= '0;
    end else if (!hold) begin
      ex_q <= ex_d;
      if (flush) begin
        fsm.state <= RUN;
        fsm.cnt   <= '0;
      end else if (in_wait) begin
        if (fsm.cnt == CNT_W'(1)) begin
          fsm.state <= RUN;
          fsm.cnt   <= '0;
        end else begin
          fsm.cnt <= fsm.cnt - CNT_W'(1);
        end
      end else if (run_hazard) begin
        fsm.pend_rd <= ex_q.rd;
        // The hazard cycle itself is the first stall; WAIT covers the rest.
        if (LOAD_STALL > 1) begin
          fsm.state <= WAIT;
          fsm.cnt   <= CNT_W'(LOAD_STALL - 1);
        end
      end
    end
  end

  assign ex_valid   = ex_q.valid;
  assign ex_is_load = ex_q.is_load;
  assign ex_rd_wen  = ex_q.rd_wen;
  assign ex_pc      = ex_q.pc;
  assign ex_regA    = ex_q.regA;
  assign ex_regB    = ex_q.regB;
  assign ex_imm     = ex_q.imm;
  assign ex_rs1     = ex_q.rs1;
  assign ex_rs2     = ex_q.rs2;
  assign ex_rd      = ex_q.rd;
  assign ex_ctrl    = ex_q.ctrl;
  assign dbg_fsm    = fsm;

`ifdef ID_EX_PERF_EN
  logic stall_evt;

  // Hold-induced stalls are not hazards and are deliberately not counted.
  assign stall_evt = !flush && ex_ready && (in_wait || run_hazard);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hazard_cnt <= '0;
    end else if (stall_evt) begin
      hazard_cnt <= sat_inc16(hazard_cnt);
    end
  end
`else
  assign hazard_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: two instances (LOAD_STALL = 1 and 3) share stimulus and
// are compared against a cycle-level behavioural model of the pipeline register.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam int DW = 32;
  localparam int CW = 16;

  typedef struct packed {
    logic          valid;
    logic          is_load;
    logic          rd_wen;
    logic [DW-1:0] pc;
    logic [DW-1:0] rega;
    logic [DW-1:0] regb;
    logic [DW-1:0] imm;
    regName_t      rs1;
    regName_t      rs2;
    regName_t      rd;
    logic [CW-1:0] ctrl;
  } rec_t;

  localparam int REC_W = $bits(rec_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          id_valid, id_use_rs1, id_use_rs2, id_is_load, id_rd_wen, ex_ready, flush;
  logic [DW-1:0] id_pc, id_regA, id_regB, id_imm;
  regName_t      id_rs1, id_rs2, id_rd;
  logic [CW-1:0] id_ctrl;

  logic          ex_valid_a, ex_is_load_a, ex_rd_wen_a, ex_valid_b, ex_is_load_b, ex_rd_wen_b;
  logic [DW-1:0] ex_pc_a, ex_regA_a, ex_regB_a, ex_imm_a, ex_pc_b, ex_regA_b, ex_regB_b, ex_imm_b;
  regName_t      ex_rs1_a, ex_rs2_a, ex_rd_a, ex_rs1_b, ex_rs2_b, ex_rd_b;
  logic [CW-1:0] ex_ctrl_a, ex_ctrl_b;
  logic          stall [2];
  logic [15:0]   hcnt [2];
  idex_fsm_t     dbg_a, dbg_b;
  rec_t          obs [2];

  assign obs[0] = {ex_valid_a, ex_is_load_a, ex_rd_wen_a, ex_pc_a, ex_regA_a, ex_regB_a,
                   ex_imm_a, ex_rs1_a, ex_rs2_a, ex_rd_a, ex_ctrl_a};
  assign obs[1] = {ex_valid_b, ex_is_load_b, ex_rd_wen_b, ex_pc_b, ex_regA_b, ex_regB_b,
                   ex_imm_b, ex_rs1_b, ex_rs2_b, ex_rd_b, ex_ctrl_b};

  id_ex_stage #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .LOAD_STALL(1)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_regA(id_regA), .id_regB(id_regB), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .id_is_load(id_is_load), .id_rd_wen(id_rd_wen), .ex_ready(ex_ready), .flush(flush),
    .ex_valid(ex_valid_a), .ex_is_load(ex_is_load_a), .ex_rd_wen(ex_rd_wen_a),
    .ex_pc(ex_pc_a), .ex_regA(ex_regA_a), .ex_regB(ex_regB_a), .ex_imm(ex_imm_a),
    .ex_rs1(ex_rs1_a), .ex_rs2(ex_rs2_a), .ex_rd(ex_rd_a), .ex_ctrl(ex_ctrl_a),
    .id_stall(stall[0]), .hazard_cnt(hcnt[0]), .dbg_fsm(dbg_a)
  );

  id_ex_stage #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .LOAD_STALL(3)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_regA(id_regA), .id_regB(id_regB), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .id_is_load(id_is_load), .id_rd_wen(id_rd_wen), .ex_ready(ex_ready), .flush(flush),
    .ex_valid(ex_valid_b), .ex_is_load(ex_is_load_b), .ex_rd_wen(ex_rd_wen_b),
    .ex_pc(ex_pc_b), .ex_regA(ex_regA_b), .ex_regB(ex_regB_b), .ex_imm(ex_imm_b),
    .ex_rs1(ex_rs1_b), .ex_rs2(ex_rs2_b), .ex_rd(ex_rd_b), .ex_ctrl(ex_ctrl_b),
    .id_stall(stall[1]), .hazard_cnt(hcnt[1]), .dbg_fsm(dbg_b)
  );

  // ---------------- reference model ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  rec_t m_ex [2];
  int   m_left [2];
  int   m_hcnt [2];
  int   ls_tab [2] = '{1, 3};
  logic [REC_W-1:0] exp_q [$];

  function automatic rec_t cur_in();
    rec_t r;
    r = '{valid: 1'b1, is_load: id_is_load, rd_wen: id_rd_wen, pc: id_pc,
          rega: id_regA, regb: id_regB, imm: id_imm, rs1: id_rs1, rs2: id_rs2,
          rd: id_rd, ctrl: id_ctrl};
    return r;
  endfunction

  function automatic bit m_hazard(int k);
    bit producer;
    producer = m_ex[k].valid && m_ex[k].is_load && m_ex[k].rd_wen && (m_ex[k].rd != 0);
    return id_valid && producer &&
           ((id_use_rs1 && id_rs1 == m_ex[k].rd) || (id_use_rs2 && id_rs2 == m_ex[k].rd));
  endfunction

  function automatic bit m_stall(int k);
    if (rst || flush) return 1'b0;
    if (!ex_ready) return 1'b1;
    if (m_left[k] > 0) return 1'b1;
    return m_hazard(k);
  endfunction

  function automatic logic [15:0] exp_hcnt(int k);
`ifdef ID_EX_PERF_EN
    return m_hcnt[k][15:0];
`else
    return 16'h0 & m_hcnt[k][15:0];
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ex[k]   = '0;
      m_left[k] = 0;
      m_hcnt[k] = 0;
    end
  endtask

  // m_left counts stall cycles still owed after the current one.
  task automatic step();
    rec_t inrec;
    inrec = cur_in();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (flush) begin
        m_ex[k]   = '0;
        m_left[k] = 0;
      end else if (!ex_ready) begin
        m_ex[k] = m_ex[k];
      end else if (m_left[k] > 0) begin
        m_ex[k]   = '0;
        m_left[k] = m_left[k] - 1;
        m_hcnt[k] = (m_hcnt[k] < 65535) ? m_hcnt[k] + 1 : 65535;
      end else if (m_hazard(k)) begin
        m_ex[k]   = '0;
        m_left[k] = ls_tab[k] - 1;
        m_hcnt[k] = (m_hcnt[k] < 65535) ? m_hcnt[k] + 1 : 65535;
      end else begin
        m_ex[k] = id_valid ? inrec : '0;
      end
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    id_valid = 0; id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_use_rs1 = 0; id_use_rs2 = 0; id_regA = '0; id_regB = '0; id_imm = '0;
    id_ctrl = '0; id_is_load = 0; id_rd_wen = 0; ex_ready = 1; flush = 0;
  endtask

  task automatic drive_instr(input logic [DW-1:0] pc, input regName_t rs1, input logic u1,
                             input regName_t rs2, input logic u2, input regName_t rd,
                             input logic ld, input logic wen);
    id_valid = 1; id_pc = pc; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_is_load = ld; id_rd_wen = wen;
    id_regA = $urandom; id_regB = $urandom; id_imm = $urandom; id_ctrl = CW'($urandom);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    set_idle();
    ex_ready = 0;
    rst = 1;
    #12;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (obs[k] !== '0) begin
        n_fail++; $display("FAIL reset_ex[%0d]: got %h want 0", k, obs[k]);
      end
      n_cmp++;
      if (hcnt[k] !== 16'h0) begin
        n_fail++; $display("FAIL reset_hcnt[%0d]: got %h want 0", k, hcnt[k]);
      end
      n_cmp++;
      if (stall[k] !== 1'b0) begin
        n_fail++; $display("FAIL reset_stall[%0d]: got %b want 0", k, stall[k]);
      end
    end
    n_cmp++;
    if (dbg_b.state !== RUN || dbg_b.cnt !== '0) begin
      n_fail++; $display("FAIL reset_state: got %b/%0d want RUN/0", dbg_b.state, dbg_b.cnt);
    end
    model_reset();
    rst = 0;
    ex_ready = 1;
    step();
  endtask

  task automatic test_pass_through();
    drive_instr(32'h100, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b0, 1'b1);
    id_regA = 32'h11; id_regB = 32'h22;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (stall[k] !== 1'b0) begin
        n_fail++; $display("FAIL pass_stall[%0d]: got %b want 0", k, stall[k]);
      end
    end
    step();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (obs[k].valid !== 1'b1 || obs[k].pc !== 32'h100 || obs[k].rega !== 32'h11 ||
          obs[k].regb !== 32'h22 || obs[k].rd !== 5'd5) begin
        n_fail++;
        $display("FAIL pass_fields[%0d]: got v=%b pc=%h a=%h b=%h rd=%0d want v=1 pc=100 a=11 b=22 rd=5",
                 k, obs[k].valid, obs[k].pc, obs[k].rega, obs[k].regb, obs[k].rd);
      end
    end
  endtask

  task automatic test_load_use();
    int stalls [2];
    int bubbles [2];
    int seen [2];
    int want_stall [2] = '{1, 3};
    int want_seen [2]  = '{2, 4};
    drive_instr(32'h200, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
    step();
    drive_instr(32'h204, 5'd3, 1'b1, 5'd8, 1'b0, 5'd6, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      stalls[k] = 0; bubbles[k] = 0; seen[k] = -1;
    end
    for (int i = 0; i < 6; i++) begin
      #1;
      for (int k = 0; k < 2; k++) if (stall[k] === 1'b1) stalls[k]++;
      step();
      for (int k = 0; k < 2; k++) begin
        if (obs[k].valid === 1'b0) bubbles[k]++;
        if (seen[k] < 0 && obs[k].valid === 1'b1 && obs[k].pc === 32'h204) seen[k] = i + 1;
      end
    end
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (stalls[k] != want_stall[k]) begin
        n_fail++; $display("FAIL loaduse_stalls[%0d]: got %0d want %0d", k, stalls[k], want_stall[k]);
      end
      n_cmp++;
      if (bubbles[k] != want_stall[k]) begin
        n_fail++; $display("FAIL loaduse_bubbles[%0d]: got %0d want %0d", k, bubbles[k], want_stall[k]);
      end
      n_cmp++;
      if (seen[k] != want_seen[k]) begin
        n_fail++; $display("FAIL loaduse_latency[%0d]: got %0d want %0d", k, seen[k], want_seen[k]);
      end
      n_cmp++;
`ifdef ID_EX_PERF_EN
      if (hcnt[k] !== 16'(want_stall[k])) begin
        n_fail++; $display("FAIL loaduse_hcnt[%0d]: got %0d want %0d", k, hcnt[k], want_stall[k]);
      end
`else
      if (hcnt[k] !== 16'h0) begin
        n_fail++; $display("FAIL loaduse_hcnt[%0d]: got %0d want 0", k, hcnt[k]);
      end
`endif
    end
  endtask

  task automatic test_rd_zero();
    logic [DW-1:0] pcs [2] = '{32'h300, 32'h314};
    for (int t = 0; t < 2; t++) begin
      // First case: load to x0. Second: load to x7 that does not write rd.
      if (t == 0) drive_instr(32'h2F0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
      else        drive_instr(32'h310, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
      step();
      if (t == 0) drive_instr(pcs[t], 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b0, 1'b1);
      else        drive_instr(pcs[t], 5'd7, 1'b1, 5'd7, 1'b1, 5'd9, 1'b0, 1'b1);
      #1;
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (stall[k] !== 1'b0) begin
          n_fail++; $display("FAIL nohaz_stall[%0d.%0d]: got %b want 0", t, k, stall[k]);
        end
      end
      step();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs[k].valid !== 1'b1 || obs[k].pc !== pcs[t]) begin
          n_fail++;
          $display("FAIL nohaz_pass[%0d.%0d]: got v=%b pc=%h want v=1 pc=%h", t, k,
                   obs[k].valid, obs[k].pc, pcs[t]);
        end
      end
    end
  endtask

  task automatic test_hold();
    rec_t held;
    logic [15:0] h0 [2];
    drive_instr(32'h400, 5'd1, 1'b0, 5'd2, 1'b0, 5'd4, 1'b1, 1'b1);
    held = cur_in();
    step();
    for (int k = 0; k < 2; k++) h0[k] = exp_hcnt(k);
    drive_instr(32'h404, 5'd4, 1'b1, 5'd0, 1'b0, 5'd10, 1'b0, 1'b1);
    ex_ready = 0;
    for (int c = 0; c < 4; c++) begin
      id_regA = $urandom; id_imm = $urandom;
      #1;
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (stall[k] !== 1'b1) begin
          n_fail++; $display("FAIL hold_stall[%0d.%0d]: got %b want 1", c, k, stall[k]);
        end
      end
      step();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs[k] !== held) begin
          n_fail++; $display("FAIL hold_ex[%0d.%0d]: got %h want %h", c, k, obs[k], held);
        end
        n_cmp++;
        if (hcnt[k] !== h0[k]) begin
          n_fail++; $display("FAIL hold_hcnt[%0d.%0d]: got %0d want %0d", c, k, hcnt[k], h0[k]);
        end
      end
    end
    flush = 1;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (stall[k] !== 1'b0) begin
        n_fail++; $display("FAIL flush_stall[%0d]: got %b want 0", k, stall[k]);
      end
    end
    step();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (obs[k] !== '0) begin
        n_fail++; $display("FAIL flush_ex[%0d]: got %h want 0", k, obs[k]);
      end
    end
    flush = 0;
    ex_ready = 1;
  endtask

  task automatic test_reset_mid_wait();
    drive_instr(32'h500, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
    step();
    drive_instr(32'h504, 5'd1, 1'b0, 5'd9, 1'b1, 5'd11, 1'b0, 1'b1);
    step();
    n_cmp++;
    if (dbg_b.state !== WAIT || dbg_b.cnt !== 3'd2) begin
      n_fail++; $display("FAIL midwait_pre: got %b/%0d want WAIT/2", dbg_b.state, dbg_b.cnt);
    end
    #2;
    rst = 1;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (obs[k] !== '0 || hcnt[k] !== 16'h0 || stall[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL midwait_rst[%0d]: got ex=%h hc=%0d st=%b want 0/0/0", k, obs[k], hcnt[k], stall[k]);
      end
    end
    model_reset();
    #2;
    rst = 0;
    drive_instr(32'h600, 5'd9, 1'b1, 5'd9, 1'b1, 5'd12, 1'b0, 1'b1);
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (stall[k] !== 1'b0) begin
        n_fail++; $display("FAIL after_rst_stall[%0d]: got %b want 0", k, stall[k]);
      end
    end
    step();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (obs[k].valid !== 1'b1 || obs[k].pc !== 32'h600) begin
        n_fail++; $display("FAIL after_rst_load[%0d]: got v=%b pc=%h want v=1 pc=600", k, obs[k].valid, obs[k].pc);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [REC_W-1:0] want;
    for (int c = 0; c < 400; c++) begin
      id_valid   = ($urandom_range(0, 3) != 0);
      id_pc      = $urandom; id_regA = $urandom; id_regB = $urandom; id_imm = $urandom;
      id_ctrl    = CW'($urandom);
      id_rs1     = regName_t'($urandom_range(0, 3));
      id_rs2     = regName_t'($urandom_range(0, 3));
      id_rd      = regName_t'($urandom_range(0, 3));
      id_use_rs1 = $urandom_range(0, 1) != 0;
      id_use_rs2 = $urandom_range(0, 1) != 0;
      id_is_load = $urandom_range(0, 1) != 0;
      id_rd_wen  = $urandom_range(0, 3) != 0;
      ex_ready   = ($urandom_range(0, 4) != 0);
      flush      = ($urandom_range(0, 15) == 0);
      #1;
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (stall[k] !== m_stall(k)) begin
          n_fail++; $display("FAIL rnd_stall[%0d.%0d]: got %b want %b", c, k, stall[k], m_stall(k));
        end
      end
      step();
      for (int k = 0; k < 2; k++) exp_q.push_back(m_ex[k]);
      for (int k = 0; k < 2; k++) begin
        want = exp_q.pop_front();
        n_cmp++;
        if (obs[k] !== rec_t'(want)) begin
          n_fail++; $display("FAIL rnd_ex[%0d.%0d]: got %h want %h", c, k, obs[k], want);
        end
        n_cmp++;
        if (hcnt[k] !== exp_hcnt(k)) begin
          n_fail++; $display("FAIL rnd_hcnt[%0d.%0d]: got %0d want %0d", c, k, hcnt[k], exp_hcnt(k));
        end
      end
    end
    set_idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_pass_through();
    test_load_use();
    test_rd_zero();
    test_hold();
    test_reset_mid_wait();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
